mx_page_mmu: RTL and testbench
==============================

Name: mx_page_mmu

Overview:
- Parametrised paging MMU for the Specialist-family cores. It generalises the single MX page register into 2^WIN_BITS independently mapped CPU windows, adds a boot-ROM overlay state machine and a flat (unmapped) mode.
- Sits between the k580vm80a address bus and the SDRAM-backed sram address/we path.
- Its mapping/control registers are reached through an I/O select decoded by the top-level MMU.

Parameters:
- ADDR_W, 16: CPU address width.
- WIN_BITS, 2: log2 of window count; windows are selected by addr[ADDR_W-1 -: WIN_BITS]. Must be ≤ PAGE_W.
- PAGE_W, 4: page number width. PHYS_W = PAGE_W + ADDR_W - WIN_BITS.
- BOOT_PAGE, 1: page aliased into every window while in BOOT.
- BOOT_EXIT, 16'h8000: first CPU access at addr ≥ BOOT_EXIT ends BOOT.

Ports:
- clk_sys, in, 1: system clock (96 MHz), all state on posedge.
- reset_n, in, 1: asynchronous, active-low reset.
- addr, in, ADDR_W: CPU address bus.
- cpu_rd, in, 1: CPU DBIN, active high.
- cpu_wr_n, in, 1: CPU write strobe, active low.
- din, in, 8: CPU data out.
- io_sel, in, 1: register-block select from the top-level decoder.
- force_flat, in, 1: tape-load override; jump straight to RUN, flat mode.
- dout, out, 8: register readback (combinational mux of registers).
- phys_addr, out, PHYS_W: translated SDRAM address (combinational).
- mem_we, out, 1: gated memory write enable.
- boot, out, 1: high while in BOOT state.
- map_en, out, 1: mapping enabled (control bit 0).
- wp_hit, out, 1: one-cycle pulse on a blocked write (only with MX_PAGE_MMU_WPROT_EN; otherwise tied 0).

Behaviour:
- Reset values (async, reset_n=0): state=BOOT, boot=1, map_en=0, map[i]=i for all windows, wp bits=0, wp_hit=0, internal old_wr=1. mem_we, phys_addr and dout follow the reset register values.
- States: BOOT, RUN. There is no path back to BOOT except reset.
- BOOT → RUN on the posedge where (cpu_rd | ~cpu_wr_n) & ~io_sel & addr ≥ BOOT_EXIT. The triggering access itself is still translated as BOOT.
- force_flat=1 in any state: next cycle state=RUN, map_en=0. It has priority over a same-cycle control-register write.
- Translation, with off = addr[ADDR_W-WIN_BITS-1:0] and w = window index:
  - BOOT: phys_addr = {BOOT_PAGE, off}.
  - RUN & map_en=0: phys_addr = {zero-extended w, off}, i.e. a flat identity map.
  - RUN & map_en=1: phys_addr = {map[w], off}.
- Translation is combinational, zero latency.
- mem_we = ~cpu_wr_n & ~io_sel & ~boot (BOOT is read-only), further gated by write protect when enabled.
- Register write: commits on the falling edge of cpu_wr_n (old_wr & ~cpu_wr_n) while io_sel=1. Exactly one commit per strobe, however long the strobe is held.
- Register index is addr[WIN_BITS:0]:
  - bit WIN_BITS = 0: map[addr[WIN_BITS-1:0]] <= din[PAGE_W-1:0].
  - bit WIN_BITS = 1: control register; bit0 = map_en, other bits ignored.
- Readback: dout = zero-extended map[index] or {7'b0, map_en}; dout = 8'hFF when io_sel=0.
- Register writes are accepted in BOOT. They take effect in translation only after BOOT exits.
- Simultaneous register write and BOOT exit in one cycle: both take effect.
- A new mapping applies to the access in the cycle after the commit edge.
- Reset asserted mid-access: all state returns to reset values immediately; any in-flight write is lost.

Optional Feature:
- MX_PAGE_MMU_WPROT_EN defined:
  - Map writes also load wp[w] <= din[7].
  - Readback bit7 = wp[w].
  - In RUN with map_en=1, a memory write to a window with wp=1 gives mem_we=0. wp_hit pulses for one cycle on the falling edge of cpu_wr_n.
- Not defined: din[7] is ignored, readback bit7=0, wp_hit tied 0, no gating.

Test Plan:
- Reset, then CPU read at 16'h1234 → phys_addr=18'h05234 (BOOT_PAGE=1, off=12'h234... with defaults off=14 bits: {4'h1,14'h1234}); boot=1; write at 16'h0100 → mem_we=0.
- Read at 16'h8000 → boot=0 next cycle. Read 16'hC010 with map_en=0 → phys_addr={4'h3,14'h0010}.
- io_sel write idx 1 data 8'h07, then control data 8'h01; read 16'h4ABC → phys_addr={4'h7,14'h0ABC}. Readback idx 1 → 8'h07.
- Hold cpu_wr_n low 20 cycles with io_sel, din changing 8'h05→8'h09 mid-strobe → map holds 5 (single commit).
- force_flat pulse in BOOT while writing control 8'h01 → state RUN, map_en=0. Read 16'h4ABC → {4'h1,14'h0ABC}.
- WPROT_EN: map[2]=8'h86, map_en=1, write 16'h8001 → mem_we=0 and one wp_hit pulse. Readback idx 2 = 8'h86. Build without the macro → readback 8'h06 and mem_we=1.

Source files
------------

// File: rtl/mx_page_mmu_if.sv
`default_nettype none
// ============================================================================
// Module   : mx_page_mmu_if
// Purpose  : CPU-side bus bundle between the core address/strobe path and the
//            paging MMU.
// Signals  : addr, cpu_rd, cpu_wr_n, din, io_sel, force_flat (CPU -> MMU)
//            dout, phys_addr, mem_we, boot, map_en, wp_hit  (MMU -> CPU/SDRAM)
// Modports : master = CPU/top-level side, slave = MMU side
// Revision : 1.0 - initial release
// ============================================================================
interface mx_page_mmu_if #(
  parameter int ADDR_W = 16,
  parameter int PHYS_W = 18
);
  logic [ADDR_W-1:0] addr;
  logic              cpu_rd;
  logic              cpu_wr_n;
  logic [7:0]        din;
  logic              io_sel;
  logic              force_flat;
  logic [7:0]        dout;
  logic [PHYS_W-1:0] phys_addr;
  logic              mem_we;
  logic              boot;
  logic              map_en;
  logic              wp_hit;

  modport master (
    output addr, cpu_rd, cpu_wr_n, din, io_sel, force_flat,
    input  dout, phys_addr, mem_we, boot, map_en, wp_hit
  );

  modport slave (
    input  addr, cpu_rd, cpu_wr_n, din, io_sel, force_flat,
    output dout, phys_addr, mem_we, boot, map_en, wp_hit
  );
endinterface
`default_nettype wire

// File: rtl/mx_page_mmu.sv
`default_nettype none
// ============================================================================
// Module   : mx_page_mmu
// Purpose  : Paging MMU for Specialist-family cores. Splits the CPU address
//            space into 2^WIN_BITS windows, each mapped to a PAGE_W-bit page.
//            A BOOT state aliases BOOT_PAGE into every window (read-only)
//            until the first CPU access at or above BOOT_EXIT; force_flat
//            jumps to RUN with mapping disabled (identity map).
// Ports    : clk_sys  - system clock, all state on posedge
//            reset_n  - asynchronous active-low reset
//            bus      - mx_page_mmu_if.slave: CPU address/strobes, register
//                       data in/out, translated address, gated write enable,
//                       boot / map_en status and wp_hit pulse
// Options  : MX_PAGE_MMU_WPROT_EN - per-window write protect bit (din[7] of
//            a map write); blocks memory writes and pulses wp_hit.
// Revision : 1.0 - initial release
// ============================================================================
module mx_page_mmu #(
  parameter int              ADDR_W    = 16,
  parameter int              WIN_BITS  = 2,
  parameter int              PAGE_W    = 4,
  parameter int              BOOT_PAGE = 1,
  parameter logic [ADDR_W-1:0] BOOT_EXIT = ADDR_W'(16'h8000)
) (
  input  wire logic          clk_sys,
  input  wire logic          reset_n,
  mx_page_mmu_if.slave       bus
);

  localparam int OFF_W = ADDR_W - WIN_BITS;
  localparam int NWIN  = 1 << WIN_BITS;

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PAGE_W-1:0]   r_map [NWIN];
  logic                r_map_en;
  logic                r_old_wr;

  logic [WIN_BITS-1:0] w_win;
  logic [OFF_W-1:0]    w_off;
  logic [WIN_BITS:0]   w_ridx;
  logic [WIN_BITS-1:0] w_rwin;
  logic                w_is_ctl;
  logic                w_wr_fall;
  logic                w_commit;
  logic                w_map_wr;
  logic                w_ctl_wr;
  logic                w_exit;
  logic [PAGE_W-1:0]   w_page;
  logic [7:0]          w_dout;
  logic                w_wp_block;
  logic                w_rd_wp;
  logic                w_wp_hit;
  logic                w_unused_din;

  assign w_win    = bus.addr[ADDR_W-1 -: WIN_BITS];
  assign w_off    = bus.addr[OFF_W-1:0];
  assign w_ridx   = bus.addr[WIN_BITS:0];
  assign w_rwin   = w_ridx[WIN_BITS-1:0];
  assign w_is_ctl = w_ridx[WIN_BITS];

  // Register writes commit once per strobe: only on the high->low transition
  // of cpu_wr_n, however long the strobe is held.
  assign w_wr_fall = r_old_wr & ~bus.cpu_wr_n;
  assign w_commit  = w_wr_fall & bus.io_sel;
  assign w_map_wr  = w_commit & ~w_is_ctl;
  assign w_ctl_wr  = w_commit & w_is_ctl;

  // Any real memory access (not a register access) at or above BOOT_EXIT.
  assign w_exit = (bus.cpu_rd | ~bus.cpu_wr_n) & ~bus.io_sel & (bus.addr >= BOOT_EXIT);

  // Only parts of din are consumed depending on PAGE_W and the build option.
  assign w_unused_din = ^bus.din;

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.force_flat) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_BOOT: if (w_exit) w_state_nxt = ST_RUN;
        ST_RUN:  w_state_nxt = ST_RUN;
        default: w_state_nxt = ST_BOOT;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Strobe history, mapping and control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_old_wr <= 1'b1;
    end else begin
      r_old_wr <= bus.cpu_wr_n;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NWIN; i++) begin
        r_map[i] <= PAGE_W'(i);
      end
    end else if (w_map_wr) begin
      r_map[w_rwin] <= bus.din[PAGE_W-1:0];
    end
  end

  // force_flat wins over a same-cycle control write.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_map_en <= 1'b0;
    end else if (bus.force_flat) begin
      r_map_en <= 1'b0;
    end else if (w_ctl_wr) begin
      r_map_en <= bus.din[0];
    end
  end

  // --------------------------------------------------------------------------
  // Optional write protect
  // --------------------------------------------------------------------------
`ifdef MX_PAGE_MMU_WPROT_EN
  logic [NWIN-1:0] r_wp;
  logic            r_wp_hit;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wp <= '0;
    end else if (w_map_wr) begin
      r_wp[w_rwin] <= bus.din[7];
    end
  end

  // Protection only matters while the map is actually in use.
  assign w_wp_block = (r_state == ST_RUN) & r_map_en & r_wp[w_win];
  assign w_rd_wp    = r_wp[w_rwin];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wp_hit <= 1'b0;
    end else begin
      r_wp_hit <= w_wr_fall & ~bus.io_sel & w_wp_block;
    end
  end

  assign w_wp_hit = r_wp_hit;
`else
  assign w_wp_block = 1'b0;
  assign w_rd_wp    = 1'b0;
  assign w_wp_hit   = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Translation (combinational, zero latency)
  // --------------------------------------------------------------------------
  always_comb begin
    w_page = PAGE_W'(BOOT_PAGE);
    if (r_state == ST_RUN) begin
      if (r_map_en) begin
        w_page = r_map[w_win];
      end else begin
        w_page = PAGE_W'(w_win);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Register readback
  // --------------------------------------------------------------------------
  always_comb begin
    w_dout = 8'hFF;
    if (bus.io_sel) begin
      if (w_is_ctl) begin
        w_dout = {7'b0, r_map_en};
      end else begin
        w_dout    = 8'(r_map[w_rwin]);
        w_dout[7] = w_rd_wp;
      end
    end
  end

  assign bus.phys_addr = {w_page, w_off};
  assign bus.mem_we    = ~bus.cpu_wr_n & ~bus.io_sel & (r_state == ST_RUN) & ~w_wp_block;
  assign bus.boot      = (r_state == ST_BOOT);
  assign bus.map_en    = r_map_en;
  assign bus.dout      = w_dout;
  assign bus.wp_hit    = w_wp_hit;

endmodule
`default_nettype wire

// File: tb/tb_mx_page_mmu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mx_page_mmu
// Purpose  : Self-checking bench for mx_page_mmu. Each vector drives one
//            cycle of CPU/register traffic; its expected outputs are queued
//            and compared mid-cycle by a negedge monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mx_page_mmu;

`ifdef MX_PAGE_MMU_WPROT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;

  mx_page_mmu_if #(.ADDR_W(16), .PHYS_W(18)) bus ();

  mx_page_mmu #(
    .ADDR_W   (16),
    .WIN_BITS (2),
    .PAGE_W   (4),
    .BOOT_PAGE(1),
    .BOOT_EXIT(16'h8000)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int          id;
    logic [15:0] addr;
    logic        rd;
    logic        wr_n;
    logic [7:0]  din;
    logic        io;
    logic        ff;
    logic [17:0] e_phys;
    logic        e_we;
    logic        e_boot;
    logic        e_map;
    logic [7:0]  e_dout;
    logic        e_wph;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[15];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(int id, logic [15:0] a, logic rd, logic wr_n,
                              logic [7:0] din, logic io, logic ff,
                              logic [17:0] p, logic we, logic bt, logic me,
                              logic [7:0] d, logic wh);
    vec_t v;
    v.id = id; v.addr = a; v.rd = rd; v.wr_n = wr_n; v.din = din;
    v.io = io; v.ff = ff; v.e_phys = p; v.e_we = we; v.e_boot = bt;
    v.e_map = me; v.e_dout = d; v.e_wph = wh;
    return v;
  endfunction

  task automatic chk(string nm, int id, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", nm, id, got, exp);
    end
  endtask

  // Scoreboard consumer: outputs sampled mid-cycle, away from the posedge.
  always @(negedge clk_sys) begin
    vec_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("phys_addr", e.id, 32'(bus.phys_addr), 32'(e.e_phys));
      chk("mem_we",    e.id, 32'(bus.mem_we),    32'(e.e_we));
      chk("boot",      e.id, 32'(bus.boot),      32'(e.e_boot));
      chk("map_en",    e.id, 32'(bus.map_en),    32'(e.e_map));
      chk("dout",      e.id, 32'(bus.dout),      32'(e.e_dout));
      chk("wp_hit",    e.id, 32'(bus.wp_hit),    32'(e.e_wph));
    end
  end

  task automatic drive(vec_t v);
    bus.addr = v.addr; bus.cpu_rd = v.rd; bus.cpu_wr_n = v.wr_n;
    bus.din = v.din; bus.io_sel = v.io; bus.force_flat = v.ff;
  endtask

  task automatic apply(vec_t v);
    @(posedge clk_sys);
    #1;
    drive(v);
    sb.push_back(v);
    @(negedge clk_sys);
  endtask

  task automatic do_reset(int id);
    @(posedge clk_sys);
    #1;
    reset_n = 1'b0;
    drive(mk(id, 16'h0000, 0, 1, 8'h00, 0, 0, 18'h0, 0, 0, 0, 8'h0, 0));
    sb.push_back(mk(id, 16'h0000, 0, 1, 8'h00, 0, 0, 18'h04000, 0, 1, 0, 8'hFF, 0));
    @(negedge clk_sys);
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    //              id  addr      rd wr din    io ff phys       we bt me dout   wh
    tbl[0]  = mk(0,  16'h1234, 1, 1, 8'h00, 0, 0, 18'h05234, 0, 1, 0, 8'hFF, 0);
    tbl[1]  = mk(1,  16'h0100, 0, 0, 8'h00, 0, 0, 18'h04100, 0, 1, 0, 8'hFF, 0);
    tbl[2]  = mk(2,  16'h0000, 0, 1, 8'h00, 0, 0, 18'h04000, 0, 1, 0, 8'hFF, 0);
    tbl[3]  = mk(3,  16'h0001, 0, 0, 8'h07, 1, 0, 18'h04001, 0, 1, 0, 8'h01, 0);
    tbl[4]  = mk(4,  16'h0001, 0, 1, 8'h00, 1, 0, 18'h04001, 0, 1, 0, 8'h07, 0);
    tbl[5]  = mk(5,  16'h0004, 0, 0, 8'h01, 1, 0, 18'h04004, 0, 1, 0, 8'h00, 0);
    tbl[6]  = mk(6,  16'h4ABC, 1, 1, 8'h00, 0, 0, 18'h04ABC, 0, 1, 1, 8'hFF, 0);
    tbl[7]  = mk(7,  16'h7FFF, 1, 1, 8'h00, 0, 0, 18'h07FFF, 0, 1, 1, 8'hFF, 0);
    tbl[8]  = mk(8,  16'h8000, 1, 1, 8'h00, 0, 0, 18'h04000, 0, 1, 1, 8'hFF, 0);
    tbl[9]  = mk(9,  16'h4ABC, 1, 1, 8'h00, 0, 0, 18'h1CABC, 0, 0, 1, 8'hFF, 0);
    tbl[10] = mk(10, 16'hC010, 0, 0, 8'h00, 0, 0, 18'h0C010, 1, 0, 1, 8'hFF, 0);
    tbl[11] = mk(11, 16'h0004, 0, 1, 8'h00, 1, 0, 18'h00004, 0, 0, 1, 8'h01, 0);
    tbl[12] = mk(12, 16'h0004, 0, 0, 8'h00, 1, 0, 18'h00004, 0, 0, 1, 8'h01, 0);
    tbl[13] = mk(13, 16'hC010, 1, 1, 8'h00, 0, 0, 18'h0C010, 0, 0, 0, 8'hFF, 0);
    tbl[14] = mk(14, 16'h4ABC, 1, 1, 8'h00, 0, 0, 18'h04ABC, 0, 0, 0, 8'hFF, 0);

    drive(mk(-1, 16'h0000, 0, 1, 8'h00, 0, 0, 18'h0, 0, 0, 0, 8'h0, 0));
    do_reset(99);

    // Boot, boot exit, mapping enable/disable.
    for (int i = 0; i < 15; i++) begin
      apply(tbl[i]);
    end

    // Long register strobe with data changing mid-strobe: one commit only.
    for (int k = 0; k < 20; k++) begin
      apply(mk(100 + k, 16'h0001, 0, 0, (k < 10) ? 8'h05 : 8'h09, 1, 0,
               18'h00001, 0, 0, 0, (k == 0) ? 8'h07 : 8'h05, 0));
    end
    apply(mk(120, 16'h0001, 0, 1, 8'h00, 1, 0, 18'h00001, 0, 0, 0, 8'h05, 0));

    // Reset restores map; force_flat beats a same-cycle control write.
    do_reset(200);
    apply(mk(201, 16'h0001, 0, 1, 8'h00, 1, 0, 18'h04001, 0, 1, 0, 8'h01, 0));
    apply(mk(202, 16'h0004, 0, 0, 8'h01, 1, 1, 18'h04004, 0, 1, 0, 8'h00, 0));
    apply(mk(203, 16'h4ABC, 1, 1, 8'h00, 0, 0, 18'h04ABC, 0, 0, 0, 8'hFF, 0));
    apply(mk(204, 16'h0004, 0, 1, 8'h00, 1, 0, 18'h00004, 0, 0, 0, 8'h00, 0));

    // Write protect on window 2.
    apply(mk(205, 16'h0002, 0, 0, 8'h86, 1, 0, 18'h00002, 0, 0, 0, 8'h02, 0));
    apply(mk(206, 16'h0002, 0, 1, 8'h00, 1, 0, 18'h00002, 0, 0, 0, WP ? 8'h86 : 8'h06, 0));
    apply(mk(207, 16'h0004, 0, 0, 8'h01, 1, 0, 18'h00004, 0, 0, 0, 8'h00, 0));
    apply(mk(208, 16'h0004, 0, 1, 8'h00, 1, 0, 18'h00004, 0, 0, 1, 8'h01, 0));
    apply(mk(209, 16'h8001, 0, 0, 8'h00, 0, 0, 18'h18001, !WP, 0, 1, 8'hFF, 0));
    apply(mk(210, 16'h8001, 0, 0, 8'h00, 0, 0, 18'h18001, !WP, 0, 1, 8'hFF, WP));
    apply(mk(211, 16'h8001, 0, 0, 8'h00, 0, 0, 18'h18001, !WP, 0, 1, 8'hFF, 0));
    apply(mk(212, 16'h8001, 0, 1, 8'h00, 0, 0, 18'h18001, 0, 0, 1, 8'hFF, 0));

    repeat (3) @(posedge clk_sys);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
